// File: rtl/rv6_bus_pkg.sv
// Shared types for the L1-to-memory bus arbiter: FSM states, bus owner and
// the round-robin grant helper.
package rv6_bus_pkg;

    localparam int unsigned RV6_LINE = 256;
    localparam int unsigned RV6_BLK  = 59;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    // When both sides are pending, the side that did not win last time goes next.
    function automatic owner_t rr_pick(input logic pend_i, input logic pend_d,
                                       input owner_t last);
        owner_t win;
        win = OWN_I;
        if (pend_i && pend_d) begin
            if (last == OWN_I) win = OWN_D;
            else               win = OWN_I;
        end else if (pend_d) begin
            win = OWN_D;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-transaction arbiter between the imem refill port and the dmem
// refill/writeback port, with a watchdog on the memory completion.
module mem_bus_arbiter
    import rv6_bus_pkg::*;
#(
    parameter int unsigned LINE  = RV6_LINE,
    parameter int unsigned BLK   = RV6_BLK,
    parameter int unsigned TMO_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BLK-1:0]  i_addr,
    input  logic            i_rd,
    output logic [LINE-1:0] i_data,
    output logic            i_dv,
    input  logic [BLK-1:0]  d_addr,
    input  logic            d_rd,
    input  logic            d_wr,
    input  logic [LINE-1:0] d_data_w,
    output logic [LINE-1:0] d_data_r,
    output logic            d_dv,
    output logic [BLK-1:0]  m_addr,
    output logic [LINE-1:0] m_data_w,
    output logic            m_rd,
    output logic            m_wr,
    input  logic [LINE-1:0] m_data_r,
    input  logic            m_dv,
    output logic            bus_err
);

    arb_state_t      state_q, state_d;
    owner_t          last_q, last_d;
    logic [BLK-1:0]  m_addr_q, m_addr_d;
    logic [LINE-1:0] m_data_w_q, m_data_w_d;
    logic            m_rd_q, m_rd_d;
    logic            m_wr_q, m_wr_d;
    logic            i_dv_q, i_dv_d;
    logic            d_dv_q, d_dv_d;
    logic [LINE-1:0] i_data_q, i_data_d;
    logic [LINE-1:0] d_data_r_q, d_data_r_d;
    logic            bus_err_q, bus_err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= OWN_I;
            m_addr_q   <= '0;
            m_data_w_q <= '0;
            m_rd_q     <= 1'b0;
            m_wr_q     <= 1'b0;
            i_dv_q     <= 1'b0;
            d_dv_q     <= 1'b0;
            i_data_q   <= '0;
            d_data_r_q <= '0;
            bus_err_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            m_addr_q   <= m_addr_d;
            m_data_w_q <= m_data_w_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            i_dv_q     <= i_dv_d;
            d_dv_q     <= d_dv_d;
            i_data_q   <= i_data_d;
            d_data_r_q <= d_data_r_d;
            bus_err_q  <= bus_err_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        logic             pend_i;
        logic             pend_d;
        logic             tmo_hit;
        logic [TMO_W-1:0] tmo_inc;
        owner_t           win;

        state_d    = state_q;
        last_d     = last_q;
        m_addr_d   = m_addr_q;
        m_data_w_d = m_data_w_q;
        m_rd_d     = m_rd_q;
        m_wr_d     = m_wr_q;
        i_dv_d     = 1'b0;
        d_dv_d     = 1'b0;
        i_data_d   = i_data_q;
        d_data_r_d = d_data_r_q;
        bus_err_d  = bus_err_q;
        tmo_d      = tmo_q;

        pend_i  = i_rd;
        pend_d  = d_rd | d_wr;
        tmo_inc = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        // Strobe stays up for exactly 2**TMO_W-1 busy cycles before giving up.
        tmo_hit = &tmo_inc;
        win     = rr_pick(pend_i, pend_d, last_q);

        case (state_q)
            IDLE: begin
                if (pend_i || pend_d) begin
                    last_d = win;
                    tmo_d  = '0;
                    if (win == OWN_I) begin
                        state_d  = I_RD;
                        m_addr_d = i_addr;
                        m_rd_d   = 1'b1;
                    end else begin
                        m_addr_d = d_addr;
                        if (d_wr) begin
                            state_d    = D_WR;
                            m_wr_d     = 1'b1;
                            m_data_w_d = d_data_w;
                        end else begin
                            state_d = D_RD;
                            m_rd_d  = 1'b1;
                        end
                    end
                end
            end
            I_RD, D_RD, D_WR: begin
                if (m_dv || tmo_hit) begin
                    state_d = RESP;
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    if (!m_dv) bus_err_d = 1'b1;
                    if (state_q == I_RD) begin
                        i_dv_d   = 1'b1;
                        i_data_d = m_dv ? m_data_r : '0;
                    end else begin
                        d_dv_d = 1'b1;
                        if (state_q == D_RD) d_data_r_d = m_dv ? m_data_r : '0;
                        else if (!m_dv)      d_data_r_d = '0;
                    end
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_addr   = m_addr_q;
    assign m_data_w = m_data_w_q;
    assign m_rd     = m_rd_q;
    assign m_wr     = m_wr_q;
    assign i_dv     = i_dv_q;
    assign d_dv     = d_dv_q;
    assign i_data   = i_data_q;
    assign d_data_r = d_data_r_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table for arbitration
// plus hand-written sequences for latency, watchdog and async reset.
module tb_mem_bus_arbiter;

    localparam int unsigned LINE = 256;
    localparam int unsigned BLK  = 59;
    localparam logic [BLK-1:0] IA = 59'h400000;
    localparam logic [BLK-1:0] DA = 59'h123;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [BLK-1:0]  i_addr = '0;
    logic            i_rd = 1'b0;
    logic [LINE-1:0] i_data;
    logic            i_dv;
    logic [BLK-1:0]  d_addr = '0;
    logic            d_rd = 1'b0;
    logic            d_wr = 1'b0;
    logic [LINE-1:0] d_data_w = '0;
    logic [LINE-1:0] d_data_r;
    logic            d_dv;
    logic [BLK-1:0]  m_addr;
    logic [LINE-1:0] m_data_w;
    logic            m_rd;
    logic            m_wr;
    logic [LINE-1:0] m_data_r = '0;
    logic            m_dv = 1'b0;
    logic            bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.LINE(LINE), .BLK(BLK), .TMO_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_data_w(d_data_w),
        .d_data_r(d_data_r), .d_dv(d_dv),
        .m_addr(m_addr), .m_data_w(m_data_w), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_r(m_data_r), .m_dv(m_dv), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       i_rd, d_rd, d_wr, m_dv;
        logic [7:0] mdr;
        logic       e_rd, e_wr, e_idv, e_ddv;
        logic       chk_addr;
        logic [BLK-1:0] e_addr;
        logic       chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, dr, dw, dv, input logic [7:0] mdr,
                                input logic er, ew, eidv, eddv,
                                input logic ca, input logic [BLK-1:0] ea,
                                input logic cd);
        vec_t v;
        v.i_rd = ir; v.d_rd = dr; v.d_wr = dw; v.m_dv = dv; v.mdr = mdr;
        v.e_rd = er; v.e_wr = ew; v.e_idv = eidv; v.e_ddv = eddv;
        v.chk_addr = ca; v.e_addr = ea; v.chk_data = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; m_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_rd", LINE'(m_rd), '0);
        chk("rst_m_wr", LINE'(m_wr), '0);
        chk("rst_i_dv", LINE'(i_dv), '0);
        chk("rst_d_dv", LINE'(d_dv), '0);
        chk("rst_m_addr", LINE'(m_addr), '0);
        chk("rst_m_data_w", m_data_w, '0);
        chk("rst_i_data", i_data, '0);
        chk("rst_d_data_r", d_data_r, '0);
        chk("rst_bus_err", LINE'(bus_err), '0);
        rst_n = 1'b1;
    endtask

    int cnt;

    initial begin
        i_addr   = IA;
        d_addr   = DA;
        d_data_w = {32{8'hA5}};

        // ir dr dw dv mdr    rd wr idv ddv ca addr cd
        vecs.push_back(mk(1,1,0,0,8'h00, 1,0,0,0, 1,DA,0)); // both -> D first
        vecs.push_back(mk(1,1,0,1,8'h11, 0,0,0,1, 0,DA,1));
        vecs.push_back(mk(1,1,0,1,8'h00, 0,0,0,0, 0,DA,0)); // m_dv in RESP ignored
        vecs.push_back(mk(1,0,0,0,8'h00, 1,0,0,0, 1,IA,0));
        vecs.push_back(mk(1,0,0,1,8'h22, 0,0,1,0, 0,IA,1));
        vecs.push_back(mk(1,1,0,0,8'h00, 0,0,0,0, 0,IA,0));
        vecs.push_back(mk(1,1,0,0,8'h00, 1,0,0,0, 1,DA,0)); // last=I -> D
        vecs.push_back(mk(1,1,0,1,8'h33, 0,0,0,1, 0,DA,1));
        vecs.push_back(mk(1,1,0,0,8'h00, 0,0,0,0, 0,DA,0));
        vecs.push_back(mk(1,1,0,0,8'h00, 1,0,0,0, 1,IA,0)); // last=D -> I
        vecs.push_back(mk(1,1,0,1,8'h44, 0,0,1,0, 0,IA,1));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 0,IA,0));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,0,0, 0,IA,0)); // m_dv in IDLE ignored
        vecs.push_back(mk(0,1,1,0,8'h00, 0,1,0,0, 1,DA,0)); // wr beats rd
        vecs.push_back(mk(0,1,1,1,8'h00, 0,0,0,1, 0,DA,0));
        vecs.push_back(mk(0,1,1,0,8'h00, 0,0,0,0, 0,DA,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 1,DA,0));
        vecs.push_back(mk(0,1,0,1,8'h55, 0,0,0,1, 0,DA,1));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 0,DA,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 0,DA,0));

        do_reset();

        foreach (vecs[k]) begin
            i_rd = vecs[k].i_rd; d_rd = vecs[k].d_rd; d_wr = vecs[k].d_wr;
            m_dv = vecs[k].m_dv; m_data_r = {32{vecs[k].mdr}};
            step();
            chk($sformatf("v%0d_m_rd", k), LINE'(m_rd), LINE'(vecs[k].e_rd));
            chk($sformatf("v%0d_m_wr", k), LINE'(m_wr), LINE'(vecs[k].e_wr));
            chk($sformatf("v%0d_i_dv", k), LINE'(i_dv), LINE'(vecs[k].e_idv));
            chk($sformatf("v%0d_d_dv", k), LINE'(d_dv), LINE'(vecs[k].e_ddv));
            if (vecs[k].chk_addr)
                chk($sformatf("v%0d_m_addr", k), LINE'(m_addr), LINE'(vecs[k].e_addr));
            if (vecs[k].chk_data && vecs[k].e_idv)
                chk($sformatf("v%0d_i_data", k), i_data, {32{vecs[k].mdr}});
            if (vecs[k].chk_data && vecs[k].e_ddv)
                chk($sformatf("v%0d_d_data_r", k), d_data_r, {32{vecs[k].mdr}});
            if (vecs[k].e_wr)
                chk($sformatf("v%0d_m_data_w", k), m_data_w, {32{8'hA5}});
        end
        m_dv = 1'b0; i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;

        // imem read, completion five cycles after the strobe rises
        do_reset();
        i_rd = 1'b1;
        m_data_r = {8{32'hCAFE_0001}};
        step();
        chk("ird_m_rd", LINE'(m_rd), 1);
        chk("ird_m_addr", LINE'(m_addr), LINE'(IA));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ird_wait_m_rd", LINE'(m_rd), 1);
            chk("ird_wait_i_dv", LINE'(i_dv), 0);
        end
        m_dv = 1'b1;
        step();
        m_dv = 1'b0;
        chk("ird_i_dv", LINE'(i_dv), 1);
        chk("ird_d_dv", LINE'(d_dv), 0);
        chk("ird_m_rd_drop", LINE'(m_rd), 0);
        chk("ird_i_data", i_data, {8{32'hCAFE_0001}});
        i_rd = 1'b0;
        m_data_r = '0;
        step();
        chk("ird_i_dv_pulse", LINE'(i_dv), 0);
        chk("ird_i_data_hold", i_data, {8{32'hCAFE_0001}});

        // dmem writeback, completion after three cycles
        d_wr = 1'b1;
        step();
        d_data_w = '0;
        chk("wr_m_wr", LINE'(m_wr), 1);
        chk("wr_m_rd", LINE'(m_rd), 0);
        chk("wr_m_data_w", m_data_w, {32{8'hA5}});
        chk("wr_m_addr", LINE'(m_addr), LINE'(DA));
        repeat (2) step();
        m_dv = 1'b1;
        step();
        m_dv = 1'b0;
        chk("wr_d_dv", LINE'(d_dv), 1);
        chk("wr_i_dv", LINE'(i_dv), 0);
        chk("wr_m_wr_drop", LINE'(m_wr), 0);
        d_wr = 1'b0;
        step();
        chk("wr_d_dv_pulse", LINE'(d_dv), 0);

        // watchdog: no completion ever arrives
        i_rd = 1'b1;
        step();
        chk("tmo_m_rd", LINE'(m_rd), 1);
        cnt = 1;
        while (m_rd && cnt < 1100) begin
            step();
            if (m_rd) cnt++;
        end
        chk("tmo_cycles", LINE'(cnt), 1023);
        chk("tmo_i_dv", LINE'(i_dv), 1);
        chk("tmo_i_data", i_data, '0);
        chk("tmo_bus_err", LINE'(bus_err), 1);
        i_rd = 1'b0;
        step();
        chk("tmo_i_dv_pulse", LINE'(i_dv), 0);
        d_rd = 1'b1;
        step();
        m_dv = 1'b1;
        step();
        m_dv = 1'b0;
        d_rd = 1'b0;
        chk("tmo_after_d_dv", LINE'(d_dv), 1);
        chk("tmo_sticky", LINE'(bus_err), 1);
        do_reset();

        // asynchronous reset in the middle of an imem read
        i_rd = 1'b1;
        step();
        chk("arst_m_rd_before", LINE'(m_rd), 1);
        rst_n = 1'b0;
        i_rd = 1'b0;
        #1;
        chk("arst_m_rd_async", LINE'(m_rd), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_dv = 1'b1;
        m_data_r = {32{8'h77}};
        step();
        m_dv = 1'b0;
        chk("arst_no_i_dv", LINE'(i_dv), 0);
        chk("arst_m_rd", LINE'(m_rd), 0);
        chk("arst_i_data", i_data, '0);
        i_rd = 1'b1;
        step();
        chk("arst_next_m_rd", LINE'(m_rd), 1);
        m_dv = 1'b1;
        step();
        m_dv = 1'b0;
        i_rd = 1'b0;
        chk("arst_next_i_dv", LINE'(i_dv), 1);
        chk("arst_next_i_data", i_data, {32{8'h77}});
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
